shift_reg_seq: RTL

SHIFT_REG_SEQ -- requirements
Module: shift_reg_seq

---
 rtl/shift_reg_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/shift_reg_seq.sv
// rtl/shift_reg_seq.sv - sequential multi-cycle shift/rotate register, one bit per clock
// Optional feature macro: SHIFT_REG_SEQ_SOUT_EN adds the s_out port (last bit shifted/rotated out).
module shift_reg_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       control,
  input  logic [AMT_W-1:0] amount,
  input  logic             s_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] reg_out,
  output logic             busy,
  output logic             done
`ifdef SHIFT_REG_SEQ_SOUT_EN
  ,
  output logic             s_out
`endif
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [2:0] OP_CLR  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_LSR  = 3'b010;
  localparam logic [2:0] OP_LSL  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;
  localparam logic [2:0] OP_SIR  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;
  localparam logic [2:0] OP_ROL  = 3'b111;

  state_t           r_state;
  logic [WIDTH-1:0] r_reg;
  logic [AMT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic             r_busy;
  logic             r_done;

  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_next;

  // One-bit step of the register for a given shift opcode
  function automatic logic [WIDTH-1:0] step_val(input logic [2:0] op,
                                                input logic [WIDTH-1:0] v,
                                                input logic sin);
    case (op)
      OP_LSR:  step_val = {1'b0, v[WIDTH-1:1]};
      OP_LSL:  step_val = {v[WIDTH-2:0], 1'b0};
      OP_ASR:  step_val = {v[WIDTH-1], v[WIDTH-1:1]};
      OP_SIR:  step_val = {sin, v[WIDTH-1:1]};
      OP_ROR:  step_val = {v[0], v[WIDTH-1:1]};
      OP_ROL:  step_val = {v[WIDTH-2:0], v[WIDTH-1]};
      default: step_val = v;
    endcase
  endfunction

  // In IDLE the step uses the incoming opcode (first step happens on the start edge);
  // in SHIFT it uses the opcode latched at start
  assign w_op   = (r_state == IDLE) ? control : r_op;
  assign w_next = step_val(w_op, r_reg, s_in);

  // Main FSM: IDLE accepts requests, SHIFT performs the remaining steps
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_reg   <= '0;
      r_cnt   <= '0;
      r_op    <= OP_CLR;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            case (control)
              OP_CLR: begin
                r_reg  <= '0;
                r_done <= 1'b1;
              end
              OP_LOAD: begin
                r_reg  <= d_in;
                r_done <= 1'b1;
              end
              default: begin
                if (amount == '0) begin
                  r_done <= 1'b1;
                end else begin
                  r_reg <= w_next;
                  r_op  <= control;
                  r_cnt <= amount - AMT_W'(1);
                  if (amount == AMT_W'(1)) begin
                    r_done <= 1'b1;
                  end else begin
                    r_state <= SHIFT;
                    r_busy  <= 1'b1;
                  end
                end
              end
            endcase
          end
        end
        SHIFT: begin
          r_reg <= w_next;
          r_cnt <= r_cnt - AMT_W'(1);
          if (r_cnt == AMT_W'(1)) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign reg_out = r_reg;
  assign busy    = r_busy;
  assign done    = r_done;

`ifdef SHIFT_REG_SEQ_SOUT_EN
  logic r_sout;
  logic w_step_en;
  logic w_out_bit;

  // A step happens on every SHIFT edge and on a start edge of a nonzero shift
  assign w_step_en = (r_state == SHIFT) ||
                     (start && (control[2:1] != 2'b00) && (amount != '0));
  // Left ops lose the MSB, right ops lose the LSB
  assign w_out_bit = ((w_op == OP_LSL) || (w_op == OP_ROL)) ? r_reg[WIDTH-1] : r_reg[0];

  // Capture the bit leaving the register on each step; clear/load/zero-amount leave it alone
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sout <= 1'b0;
    end else if (w_step_en) begin
      r_sout <= w_out_bit;
    end
  end

  assign s_out = r_sout;
`endif

endmodule
